// File: rtl/tdm_pkg.sv
// Shared definitions for the time-division mux link (receive demux and
// transmit-side sequencer): FSM state encoding and frame length helper.
package tdm_pkg;

  // IDLE: waiting for slot 0; COLLECT: data slots in flight;
  // PARITY: waiting for the trailing parity slot (parity build only).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PARITY  = 2'd2
  } tdm_state_e;

  // Number of data slots in one frame for a select width of sel_w bits.
  function automatic int slots_f(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter shared by both ends of the link: clear, load-1 and
// increment, wrapping naturally modulo 2**W. Priority: clr > load1 > inc.
module tdm_slot_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: load1 restarts at slot 1 because slot 0 is consumed by the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d    = '0;
      cnt_d[0] = 1'b1;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tdm_demux.sv
// Receive end of the TDM link: steps a slot counter over 2**m serial bits,
// assembles them in a shadow register and publishes the finished word with a
// one-cycle out_valid strobe. Protocol violations give a one-cycle err pulse.
// Build option: define TDM_PARITY_EN to expect one even-parity slot after the
// last data slot; the word is published only when parity matches.
//
// Handshake: a slot is consumed on every rising clk edge where sin_valid=1;
// frame_start is meaningful only together with sin_valid and marks slot 0.
// There is no backpressure; sin_valid=0 simply stalls the frame.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int m     = 3,
  localparam int SLOTS = slots_f(m)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [SLOTS-1:0] out,
  output logic             out_valid,
  output logic [m-1:0]     slot,
  output logic             busy,
  output logic             err,
  output tdm_state_e       dbg_state
);

  localparam logic [m-1:0] LAST_SLOT = m'(SLOTS - 1);

  tdm_state_e       state_d, state_q;
  logic [SLOTS-1:0] shadow_d, shadow_q;
  logic [SLOTS-1:0] out_d, out_q;
  logic             out_valid_d, out_valid_q;
  logic             err_d, err_q;
  logic [SLOTS-1:0] word;
  logic             cnt_clr, cnt_load1, cnt_inc;
  logic [m-1:0]     slot_cnt;

  tdm_slot_counter #(.W(m)) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .cnt   (slot_cnt)
  );

  // Next-state, shadow and output computation for one consumed slot.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    out_valid_d   = 1'b0;
    err_d         = 1'b0;
    cnt_clr       = 1'b0;
    cnt_load1     = 1'b0;
    cnt_inc       = 1'b0;
    // Shadow with the current bit merged in at the current slot.
    word          = shadow_q;
    word[slot_cnt] = sin;

    case (state_q)
      ST_IDLE: begin
        if (sin_valid) begin
          if (frame_start) begin
            shadow_d    = '0;
            shadow_d[0] = sin;
            cnt_load1   = 1'b1;
            state_d     = ST_COLLECT;
          end else begin
            // Data with no frame in progress cannot be placed: drop it.
            err_d = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        if (sin_valid) begin
          if (frame_start) begin
            // Early resync: discard the partial frame, this bit is slot 0.
            err_d       = 1'b1;
            shadow_d    = '0;
            shadow_d[0] = sin;
            cnt_load1   = 1'b1;
          end else begin
            shadow_d = word;
            if (slot_cnt == LAST_SLOT) begin
`ifdef TDM_PARITY_EN
              // Counter wraps to 0 while the parity slot is awaited.
              cnt_inc = 1'b1;
              state_d = ST_PARITY;
`else
              out_d       = word;
              out_valid_d = 1'b1;
              cnt_clr     = 1'b1;
              state_d     = ST_IDLE;
`endif
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
      end

`ifdef TDM_PARITY_EN
      ST_PARITY: begin
        if (sin_valid) begin
          if (frame_start) begin
            err_d       = 1'b1;
            shadow_d    = '0;
            shadow_d[0] = sin;
            cnt_load1   = 1'b1;
            state_d     = ST_COLLECT;
          end else begin
            // Even parity: parity bit equals XOR of the data bits.
            if (sin == ^shadow_q) begin
              out_d       = shadow_q;
              out_valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State, shadow and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // A frame is partially received whenever we are past IDLE (the parity
  // slot, when present, is still part of the frame).
  assign busy      = (state_q != ST_IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign slot      = slot_cnt;
  assign dbg_state = state_q;

endmodule
